ram_fifo_ctrl: RTL and testbench
================================

Name: ram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly upstream of the n-bit-address, m-bit-word dual-port RAM.
- Converts a push/pop stream interface into RAM write/read strobes and addresses.
- Tracks occupancy and registers the RAM read word into a valid-tagged output.
- Depth is 2^n words; the RAM itself stays outside this block.

Parameters:
n, 4, address width; FIFO depth = 2^n
m, 4, data word width
AF_LEVEL, 2, almost-full/almost-empty margin in words (used only with FIFO_ALMOST_EN)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
push  input  1  write request; data_in sampled when accepted
data_in  input  m  word to enqueue
pop  input  1  read request
data_out  output  m  dequeued word, registered
data_valid  output  1  one-cycle pulse; data_out holds a newly popped word
full  output  1  count == 2^n
empty  output  1  count == 0
count  output  n+1  current occupancy, 0..2^n
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty
ram_w  output  1  to RAM w
ram_addr_in  output  n  to RAM addr_in (write pointer)
ram_data_in  output  m  to RAM data_in (passthrough of data_in)
ram_r  output  1  to RAM r
ram_addr_out  output  n  to RAM addr_out (read pointer)
ram_data_out  input  m  from RAM data_out

Behaviour:
- Reset (rst_n low, async):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - data_out = 0, data_valid = 0, overflow = 0, underflow = 0.
  - empty = 1, full = 0.
- Acceptance:
  - push_ok = push & ~full.
  - pop_ok = pop & ~empty.
  - Flags are evaluated on pre-edge state.
  - A push into an empty FIFO is not poppable in the same cycle; no fall-through.
- RAM strobes (combinational from current state):
  - ram_w = push_ok, ram_addr_in = wr_ptr, ram_data_in = data_in.
  - ram_r = pop_ok, ram_addr_out = rd_ptr.
- Clock edge:
  - push_ok: wr_ptr <= wr_ptr+1, modulo 2^n; wraps 2^n-1 -> 0.
  - pop_ok:
    - data_out <= ram_data_out.
    - data_valid <= 1.
    - rd_ptr <= rd_ptr+1, modulo 2^n.
  - No pop_ok: data_valid <= 0 and data_out holds its value.
- count:
  - push_ok only: +1.
  - pop_ok only: -1.
  - Both, or neither: unchanged.
  - count is n+1 bits, so it never wraps.
- Latency: a pop accepted at edge k gives data_valid=1 with the word in the cycle after edge k (1 cycle).
- Simultaneous push & pop:
  - When full: pop accepted, push rejected; overflow sets; count drops to 2^n-1.
  - When empty: push accepted, pop rejected; underflow sets; count becomes 1.
  - Otherwise both are accepted and count is unchanged.
- Sticky errors:
  - overflow <= 1 on push & full; underflow <= 1 on pop & empty.
  - Both clear only on reset.
- Reset mid-operation: all state clears immediately; any word already in the RAM is abandoned (pointers return to 0).
- Ordering: strict FIFO. The word written at wr_ptr=i is returned by the pop at rd_ptr=i.

Optional Feature:
- Macro: FIFO_ALMOST_EN.
- Defined: adds two outputs.
  - almost_full (1) = (count >= 2^n - AF_LEVEL).
  - almost_empty (1) = (count <= AF_LEVEL).
  - Both are combinational from registered count.
  - Reset values: almost_full = 0, almost_empty = 1.
- Not defined: neither port exists and AF_LEVEL is unused. All other behaviour is identical.

Test Plan:
- Reset, then idle 3 cycles -> empty=1, full=0, count=0, data_valid=0, data_out=0, ram_w=0, ram_r=0.
- n=4: push 0x1..0xF,0x0 (16 words) -> count=16, full=1; 17th push (0x5) -> ram_w=0, overflow=1, count stays 16.
- Pop 16 times back-to-back -> data_valid high 16 consecutive cycles, data_out = 0x1..0xF,0x0 in order; then empty=1; one further pop -> underflow=1, data_valid=0.
- Push 10, pop 10, then push 10 -> wr_ptr wraps 15->0; next 10 pops return the second batch in order with ram_addr_out sequence 10..15,0..3.
- Count=5, assert push & pop for 4 cycles -> count stays 5, 4 data_valid pulses. Full with push & pop -> count=15, overflow=1. Empty with push & pop -> count=1, underflow=1, data_valid=0.
- Mid-stream (count=7): pulse rst_n low for half a cycle -> count=0, empty=1, data_valid=0 immediately. With FIFO_ALMOST_EN and AF_LEVEL=2: almost_empty=1 at count 0..2, almost_full=1 at count 14..16.

Source files
------------

// File: rtl/ram_fifo_if.sv
// Push/pop stream bundle of the RAM-backed FIFO controller.
// With FIFO_ALMOST_EN defined the bundle also carries almost_full/almost_empty.
interface ram_fifo_if #(
  parameter int n = 4,
  parameter int m = 4
);
  logic         push;
  logic [m-1:0] data_in;
  logic         pop;
  logic [m-1:0] data_out;
  logic         data_valid;
  logic         full;
  logic         empty;
  logic [n:0]   count;
  logic         overflow;
  logic         underflow;
`ifdef FIFO_ALMOST_EN
  logic         almost_full;
  logic         almost_empty;

  modport master (
    output push, data_in, pop,
    input  data_out, data_valid, full, empty, count, overflow, underflow,
           almost_full, almost_empty
  );
  modport slave (
    input  push, data_in, pop,
    output data_out, data_valid, full, empty, count, overflow, underflow,
           almost_full, almost_empty
  );
`else
  modport master (
    output push, data_in, pop,
    input  data_out, data_valid, full, empty, count, overflow, underflow
  );
  modport slave (
    input  push, data_in, pop,
    output data_out, data_valid, full, empty, count, overflow, underflow
  );
`endif
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external 2^n x m dual-port RAM; one-cycle registered read.
// Optional macro FIFO_ALMOST_EN adds almost_full/almost_empty with margin AF_LEVEL.
module ram_fifo_ctrl #(
  parameter int n        = 4,
  parameter int m        = 4,
  parameter int AF_LEVEL = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_fifo_if.slave    bus,
  output logic         ram_w,
  output logic [n-1:0] ram_addr_in,
  output logic [m-1:0] ram_data_in,
  output logic         ram_r,
  output logic [n-1:0] ram_addr_out,
  input  logic [m-1:0] ram_data_out
);

  localparam logic [n:0] DEPTH = {1'b1, {n{1'b0}}};

  if (AF_LEVEL < 0 || AF_LEVEL > (1 << n)) begin : g_af_range
    $error("AF_LEVEL must lie in 0..2^n");
  end

  logic [n-1:0] wr_ptr;
  logic [n-1:0] rd_ptr;
  logic [n:0]   count;
  logic [m-1:0] data_out;
  logic         data_valid;
  logic         overflow;
  logic         underflow;
  logic         full;
  logic         empty;
  logic         push_ok;
  logic         pop_ok;

  // Flags come from the registered count, so acceptance uses pre-edge state
  // and a word pushed into an empty FIFO cannot be popped in the same cycle.
  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign push_ok = bus.push & ~full;
  assign pop_ok  = bus.pop & ~empty;

  assign ram_w        = push_ok;
  assign ram_addr_in  = wr_ptr;
  assign ram_data_in  = bus.data_in;
  assign ram_r        = pop_ok;
  assign ram_addr_out = rd_ptr;

  // RAM read word is captured at the pop edge and presented one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= ram_data_out;
      end
      data_valid <= pop_ok;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.push & full)  overflow  <= 1'b1;
      if (bus.pop  & empty) underflow <= 1'b1;
    end
  end

  assign bus.data_out   = data_out;
  assign bus.data_valid = data_valid;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.count      = count;
  assign bus.overflow   = overflow;
  assign bus.underflow  = underflow;

`ifdef FIFO_ALMOST_EN
  localparam logic [n:0] AE_TH = (n+1)'(AF_LEVEL);
  localparam logic [n:0] AF_TH = DEPTH - AE_TH;

  assign bus.almost_full  = (count >= AF_TH);
  assign bus.almost_empty = (count <= AE_TH);
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM, occupancy model and a word scoreboard.
module tb_ram_fifo_ctrl;
  localparam int N = 4;
  localparam int M = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_fifo_if #(.n(N), .m(M)) bus ();

  logic         ram_w, ram_r;
  logic [N-1:0] ram_addr_in, ram_addr_out;
  logic [M-1:0] ram_data_in, ram_data_out;
  logic [M-1:0] mem [DEPTH];

  ram_fifo_ctrl #(.n(N), .m(M), .AF_LEVEL(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .ram_w        (ram_w),
    .ram_addr_in  (ram_addr_in),
    .ram_data_in  (ram_data_in),
    .ram_r        (ram_r),
    .ram_addr_out (ram_addr_out),
    .ram_data_out (ram_data_out)
  );

  always @(posedge clk) if (ram_w) mem[ram_addr_in] <= ram_data_in;
  assign ram_data_out = mem[ram_addr_out];

  int tests = 0;
  int fails = 0;
  int m_count;
  logic m_ovf, m_unf, exp_valid;
  logic [M-1:0] sb [$];
  logic [M-1:0] exp_w;
  logic w_seen, r_seen;
  logic [N-1:0] raddr_seen;

  task automatic model_clear();
    m_count = 0; m_ovf = 1'b0; m_unf = 1'b0; exp_valid = 1'b0;
    sb.delete();
  endtask

  task automatic do_reset();
    bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
  endtask

  // Drives one cycle of stimulus; expected words enter the scoreboard here.
  task automatic cycle(input logic p, input logic [M-1:0] d, input logic q);
    logic wok;
    bus.push = p; bus.data_in = d; bus.pop = q;
    #1;
    w_seen = ram_w; r_seen = ram_r; raddr_seen = ram_addr_out;
    wok = p && (m_count < DEPTH);
    exp_valid = q && (m_count > 0);
    if (p && m_count == DEPTH) m_ovf = 1'b1;
    if (q && m_count == 0) m_unf = 1'b1;
    if (wok) sb.push_back(d);
    m_count = m_count + int'(wok) - int'(exp_valid);
    @(posedge clk); #1;
    bus.push = 1'b0; bus.pop = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) cycle(1'b0, '0, 1'b0);
    tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
    tests++; if (bus.full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", bus.full); end
    tests++; if (bus.count !== 5'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    tests++; if (bus.data_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", bus.data_valid); end
    tests++; if (bus.data_out !== 4'h0) begin fails++; $display("FAIL reset_data got %h exp 0", bus.data_out); end
    tests++; if (w_seen !== 1'b0) begin fails++; $display("FAIL reset_ram_w got %b exp 0", w_seen); end
    tests++; if (r_seen !== 1'b0) begin fails++; $display("FAIL reset_ram_r got %b exp 0", r_seen); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 4'((i + 1) % 16), 1'b0);
      tests++; if (w_seen !== 1'b1) begin fails++; $display("FAIL fill_ram_w[%0d] got %b exp 1", i, w_seen); end
    end
    tests++; if (bus.count !== 5'd16) begin fails++; $display("FAIL fill_count got %0d exp 16", bus.count); end
    tests++; if (bus.full !== 1'b1) begin fails++; $display("FAIL fill_full got %b exp 1", bus.full); end
    cycle(1'b1, 4'h5, 1'b0);
    tests++; if (w_seen !== 1'b0) begin fails++; $display("FAIL ovf_ram_w got %b exp 0", w_seen); end
    tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b exp 1", bus.overflow); end
    tests++; if (bus.count !== 5'd16) begin fails++; $display("FAIL ovf_count got %0d exp 16", bus.count); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1);
      tests++; if (bus.data_valid !== 1'b1) begin fails++; $display("FAIL drain_valid[%0d] got %b exp 1", i, bus.data_valid); end
      exp_w = 4'((i + 1) % 16);
      if (sb.size() > 0) void'(sb.pop_front());
      tests++; if (bus.data_out !== exp_w) begin fails++; $display("FAIL drain_data[%0d] got %h exp %h", i, bus.data_out, exp_w); end
    end
    tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL drain_empty got %b exp 1", bus.empty); end
    cycle(1'b0, '0, 1'b1);
    tests++; if (r_seen !== 1'b0) begin fails++; $display("FAIL unf_ram_r got %b exp 0", r_seen); end
    tests++; if (bus.underflow !== 1'b1) begin fails++; $display("FAIL unf_flag got %b exp 1", bus.underflow); end
    tests++; if (bus.data_valid !== 1'b0) begin fails++; $display("FAIL unf_valid got %b exp 0", bus.data_valid); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) cycle(1'b1, 4'(i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, 1'b1);
      exp_w = sb.pop_front();
      tests++; if (bus.data_out !== exp_w) begin fails++; $display("FAIL wrap_first[%0d] got %h exp %h", i, bus.data_out, exp_w); end
    end
    for (int i = 0; i < 10; i++) cycle(1'b1, 4'((i + 3) % 16), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, 1'b1);
      tests++; if (raddr_seen !== 4'((10 + i) % 16)) begin fails++; $display("FAIL wrap_addr[%0d] got %0d exp %0d", i, raddr_seen, (10 + i) % 16); end
      exp_w = sb.pop_front();
      tests++; if (bus.data_valid !== 1'b1 || bus.data_out !== exp_w) begin fails++; $display("FAIL wrap_second[%0d] got %b/%h exp 1/%h", i, bus.data_valid, bus.data_out, exp_w); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'(9 + i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 4'(2 * i + 1), 1'b1);
      tests++; if (bus.count !== 5'd5) begin fails++; $display("FAIL b2b_count[%0d] got %0d exp 5", i, bus.count); end
      exp_w = sb.pop_front();
      tests++; if (bus.data_valid !== 1'b1 || bus.data_out !== exp_w) begin fails++; $display("FAIL b2b_data[%0d] got %b/%h exp 1/%h", i, bus.data_valid, bus.data_out, exp_w); end
    end
    for (int i = 0; i < 11; i++) cycle(1'b1, 4'(i), 1'b0);
    cycle(1'b1, 4'hE, 1'b1);
    tests++; if (bus.count !== 5'd15) begin fails++; $display("FAIL full_pp_count got %0d exp 15", bus.count); end
    tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL full_pp_ovf got %b exp 1", bus.overflow); end
    exp_w = sb.pop_front();
    tests++; if (bus.data_valid !== 1'b1 || bus.data_out !== exp_w) begin fails++; $display("FAIL full_pp_data got %b/%h exp 1/%h", bus.data_valid, bus.data_out, exp_w); end
    do_reset();
    cycle(1'b1, 4'h7, 1'b1);
    tests++; if (w_seen !== 1'b1 || r_seen !== 1'b0) begin fails++; $display("FAIL empty_pp_strobes got w=%b r=%b exp w=1 r=0", w_seen, r_seen); end
    tests++; if (bus.count !== 5'd1) begin fails++; $display("FAIL empty_pp_count got %0d exp 1", bus.count); end
    tests++; if (bus.underflow !== 1'b1) begin fails++; $display("FAIL empty_pp_unf got %b exp 1", bus.underflow); end
    tests++; if (bus.data_valid !== 1'b0) begin fails++; $display("FAIL empty_pp_valid got %b exp 0", bus.data_valid); end
    cycle(1'b0, '0, 1'b1);
    exp_w = sb.pop_front();
    tests++; if (bus.data_valid !== 1'b1 || bus.data_out !== exp_w) begin fails++; $display("FAIL empty_pp_later got %b/%h exp 1/%h", bus.data_valid, bus.data_out, exp_w); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'(15 - i), 1'b0);
    cycle(1'b1, 4'h3, 1'b1);
    cycle(1'b0, '0, 1'b1);
    tests++; if (bus.count !== 5'd7 || bus.data_valid !== 1'b1) begin fails++; $display("FAIL pre_rst got count=%0d valid=%b exp 7/1", bus.count, bus.data_valid); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bus.count !== 5'd0) begin fails++; $display("FAIL arst_count got %0d exp 0", bus.count); end
    tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL arst_empty got %b exp 1", bus.empty); end
    tests++; if (bus.data_valid !== 1'b0) begin fails++; $display("FAIL arst_valid got %b exp 0", bus.data_valid); end
    tests++; if (bus.data_out !== 4'h0) begin fails++; $display("FAIL arst_data got %h exp 0", bus.data_out); end
    #4 rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
    cycle(1'b1, 4'hA, 1'b0);
    tests++; if (ram_addr_in !== 4'd1) begin fails++; $display("FAIL arst_wrptr got %0d exp 1", ram_addr_in); end
    cycle(1'b0, '0, 1'b1);
    tests++; if (raddr_seen !== 4'd0) begin fails++; $display("FAIL arst_rdptr got %0d exp 0", raddr_seen); end
    exp_w = sb.pop_front();
    tests++; if (bus.data_valid !== 1'b1 || bus.data_out !== exp_w) begin fails++; $display("FAIL arst_resume got %b/%h exp 1/%h", bus.data_valid, bus.data_out, exp_w); end
  endtask

`ifdef FIFO_ALMOST_EN
  task automatic test_almost();
    do_reset();
    for (int c = 0; c <= DEPTH; c++) begin
      tests++; if (bus.almost_empty !== (c <= 2)) begin fails++; $display("FAIL almost_empty[%0d] got %b exp %b", c, bus.almost_empty, (c <= 2)); end
      tests++; if (bus.almost_full !== (c >= 14)) begin fails++; $display("FAIL almost_full[%0d] got %b exp %b", c, bus.almost_full, (c >= 14)); end
      if (c < DEPTH) cycle(1'b1, 4'(c), 1'b0);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rst_n = 1'b1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0;
    model_clear();
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_back_to_back();
    test_async_reset();
`ifdef FIFO_ALMOST_EN
    test_almost();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
